// File: rtl/ocra_stream_pkg.sv
// Shared definitions for the sample-streaming read path: player FSM encoding and default widths.
package ocra_stream_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int DIV_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } player_state_e;

endpackage

// File: rtl/sample_skid_buffer.sv
// Small synchronous prefetch FIFO between the dual-clock sample FIFO and the fixed-rate player.
// Flush has priority over push/pop; a push into a full buffer is accepted only alongside a pop.
module sample_skid_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        head,
  output logic [$clog2(BUF_DEPTH):0]   occ
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(BUF_DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem_r [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [OCC_W-1:0]      occ_r;
  logic                  pop_ok_s;
  logic                  push_ok_s;

  // Accept gating: never pop empty, never overwrite unread data.
  always_comb begin
    pop_ok_s  = pop & (occ_r != {OCC_W{1'b0}});
    push_ok_s = push & ((occ_r != DEPTH_OCC) | pop_ok_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign head = mem_r[rd_ptr_r];
  assign occ  = occ_r;

endmodule

// File: rtl/fifo_sample_player.sv
// Read-side player: prefetches from the sample FIFO and replays words at one strobe per interval+1 clocks.
// Build option SAMPLE_PLAYER_UNDERRUN_HALT_EN: an underrun tick returns the player to IDLE.
module fifo_sample_player #(
  parameter int DATA_WIDTH = ocra_stream_pkg::DATA_WIDTH,
  parameter int DIV_WIDTH  = ocra_stream_pkg::DIV_WIDTH,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DIV_WIDTH-1:0]  interval,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_valid,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_strobe,
  output logic                  busy,
  output logic                  underrun,
  output logic [CNT_WIDTH-1:0]  sample_count
);

  import ocra_stream_pkg::*;

  localparam int OCC_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [OCC_W-1:0]     DEPTH_OCC = OCC_W'(BUF_DEPTH);
  localparam logic [OCC_W-1:0]     OCC_ONE   = OCC_W'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  player_state_e         state_r;
  player_state_e         state_nxt_s;
  logic [DIV_WIDTH-1:0]  interval_r;
  logic [DIV_WIDTH-1:0]  div_cnt_r;
  logic [OCC_W-1:0]      occ_s;
  logic [OCC_W-1:0]      inflight_r;
  logic [OCC_W:0]        pending_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic                  busy_s;
  logic                  start_ok_s;
  logic                  tick_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  flush_s;
  logic                  underrun_tick_s;
  logic                  halt_s;

`ifdef SAMPLE_PLAYER_UNDERRUN_HALT_EN
  assign halt_s = underrun_tick_s;
`else
  assign halt_s = 1'b0;
`endif

  // Control decode; stop masks both start and the sample tick.
  always_comb begin
    busy_s          = (state_r != ST_IDLE);
    start_ok_s      = start & ~stop & (state_r == ST_IDLE);
    tick_s          = (state_r == ST_RUN) & (div_cnt_r == {DIV_WIDTH{1'b0}}) & ~stop;
    pop_s           = tick_s & (occ_s != {OCC_W{1'b0}});
    underrun_tick_s = tick_s & (occ_s == {OCC_W{1'b0}});
    flush_s         = stop | halt_s;
    push_s          = fifo_rd_valid & busy_s & ~flush_s;
    pending_s       = {1'b0, occ_s} + {1'b0, inflight_r};
  end

  assign busy       = busy_s;
  assign fifo_rd_en = busy_s & ~fifo_empty & (pending_s < {1'b0, DEPTH_OCC});

  sample_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_s),
    .push      (push_s),
    .push_data (fifo_rd_data),
    .pop       (pop_s),
    .head      (head_s),
    .occ       (occ_s)
  );

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_nxt_s = ST_PRIME;
        else            state_nxt_s = ST_IDLE;
      end
      ST_PRIME: begin
        if (stop)                    state_nxt_s = ST_IDLE;
        else if (occ_s == DEPTH_OCC) state_nxt_s = ST_RUN;
        else                         state_nxt_s = ST_PRIME;
      end
      ST_RUN: begin
        if (stop | halt_s) state_nxt_s = ST_IDLE;
        else               state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Reads still in flight survive a stop; their data is dropped on arrival while IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= {OCC_W{1'b0}};
    end else begin
      case ({fifo_rd_en, fifo_rd_valid & (inflight_r != {OCC_W{1'b0}})})
        2'b10:   inflight_r <= inflight_r + OCC_ONE;
        2'b01:   inflight_r <= inflight_r - OCC_ONE;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Interval latch and sample-rate divider, loaded on RUN entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      interval_r <= {DIV_WIDTH{1'b0}};
      div_cnt_r  <= {DIV_WIDTH{1'b0}};
    end else begin
      if (start_ok_s) interval_r <= interval;
      if ((state_r == ST_PRIME) && (state_nxt_s == ST_RUN)) begin
        div_cnt_r <= interval_r;
      end else if (state_r == ST_RUN) begin
        if (div_cnt_r == {DIV_WIDTH{1'b0}}) div_cnt_r <= interval_r;
        else                                div_cnt_r <= div_cnt_r - DIV_ONE;
      end else begin
        div_cnt_r <= div_cnt_r;
      end
    end
  end

  // Sample output, strobe and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout         <= {DATA_WIDTH{1'b0}};
      dout_strobe  <= 1'b0;
      underrun     <= 1'b0;
      sample_count <= {CNT_WIDTH{1'b0}};
    end else begin
      dout_strobe <= pop_s;
      if (pop_s) dout <= head_s;
      if (start_ok_s)           underrun <= 1'b0;
      else if (underrun_tick_s) underrun <= 1'b1;
      if (start_ok_s)  sample_count <= {CNT_WIDTH{1'b0}};
      else if (pop_s)  sample_count <= sample_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fifo_sample_player.sv
// Directed bench for fifo_sample_player with a behavioural read-side FIFO model and expected-sample queue.
// Expectations follow SAMPLE_PLAYER_UNDERRUN_HALT_EN when the bench is built with it.
module tb_fifo_sample_player;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] interval = 16'd0;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data = 16'd0;
  logic        fifo_rd_valid = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [15:0] dout;
  logic        dout_strobe;
  logic        busy;
  logic        underrun;
  logic [31:0] sample_count;

  logic        wr_req = 1'b0;
  logic [15:0] wr_data = 16'd0;
  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  int          cyc = 0;
  int          last_cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;

  fifo_sample_player dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .interval      (interval),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_valid (fifo_rd_valid),
    .fifo_empty    (fifo_empty),
    .dout          (dout),
    .dout_strobe   (dout_strobe),
    .busy          (busy),
    .underrun      (underrun),
    .sample_count  (sample_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-side FIFO model: data one clock after an accepted read, registered empty flag.
  always @(posedge clk) begin
    fifo_rd_valid <= 1'b0;
    if (wr_req) fifo_q.push_back(wr_data);
    if (fifo_rd_en && fifo_q.size() > 0) begin
      fifo_rd_data  <= fifo_q.pop_front();
      fifo_rd_valid <= 1'b1;
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_write(input logic [15:0] v);
    wr_req  = 1'b1;
    wr_data = v;
    @(negedge clk);
    wr_req  = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] iv);
    interval = iv;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // Waits (bounded) for the next strobe and compares dout to the scoreboard head.
  task automatic wait_strobe(input string tag, input int budget, input int gap);
    int n;
    logic [15:0] e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dout_strobe !== 1'b1 && n < budget);
    check({tag, "_seen"}, {63'd0, dout_strobe}, 64'd1);
    if (dout_strobe === 1'b1) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 16'hxxxx;
      check({tag, "_dout"}, {48'd0, dout}, {48'd0, e});
      if (gap > 0) check({tag, "_gap"}, 64'(cyc - last_cyc), 64'(gap));
      last_cyc = cyc;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dout", {48'd0, dout}, 64'd0);
    check("rst_strobe", {63'd0, dout_strobe}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_underrun", {63'd0, underrun}, 64'd0);
    check("rst_count", {32'd0, sample_count}, 64'd0);
    check("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: 1..8 at interval 3
    for (int i = 1; i <= 8; i++) begin
      fifo_write(16'(i));
      exp_q.push_back(16'(i));
    end
    check("t1_idle_no_rd", {63'd0, fifo_rd_en}, 64'd0);
    pulse_start(16'd3);
    check("t1_busy", {63'd0, busy}, 64'd1);
    for (int i = 1; i <= 8; i++) wait_strobe($sformatf("t1_s%0d", i), 40, (i > 1) ? 4 : 0);
    check("t1_count", {32'd0, sample_count}, 64'd8);
    check("t1_no_underrun", {63'd0, underrun}, 64'd0);
    repeat (3) @(negedge clk);
    check("t1_underrun_early", {63'd0, underrun}, 64'd0);
    @(negedge clk);
    check("t1_underrun_tick", {63'd0, underrun}, 64'd1);
    check("t1_no_strobe", {63'd0, dout_strobe}, 64'd0);
    check("t1_dout_hold", {48'd0, dout}, 64'd8);

`ifdef SAMPLE_PLAYER_UNDERRUN_HALT_EN
    // Test 3b: halt on underrun
    check("t3b_busy_drop", {63'd0, busy}, 64'd0);
    fifo_write(16'd9);
    exp_q.push_back(16'd9);
    repeat (3) begin
      @(negedge clk);
      check("t3b_no_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    end
`else
    // Test 3: keep running through underrun
    check("t3_busy", {63'd0, busy}, 64'd1);
    fifo_write(16'd9);
    exp_q.push_back(16'd9);
    wait_strobe("t3_s9", 20, 0);
    check("t3_underrun_sticky", {63'd0, underrun}, 64'd1);
    check("t3_busy_after", {63'd0, busy}, 64'd1);
    check("t3_count", {32'd0, sample_count}, 64'd9);
    pulse_stop();
    check("t3_stop_busy", {63'd0, busy}, 64'd0);
    check("t3_stop_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    check("t3_stop_dout_hold", {48'd0, dout}, 64'd9);
    check("t3_stop_count_hold", {32'd0, sample_count}, 64'd9);
`endif
    check("t2_pre_underrun", {63'd0, underrun}, 64'd1);

    // Test 2: interval 0, one sample per clock
    for (int i = 0; i < 16; i++) begin
      fifo_write(16'(100 + i));
      exp_q.push_back(16'(100 + i));
    end
    pulse_start(16'd0);
    check("t2_underrun_clr", {63'd0, underrun}, 64'd0);
    check("t2_count_clr", {32'd0, sample_count}, 64'd0);
    wait_strobe("t2_first", 20, 0);
    while (exp_q.size() > 0) wait_strobe("t2_run", 3, 1);
    check("t2_no_underrun", {63'd0, underrun}, 64'd0);
    @(negedge clk);
    check("t2_underrun", {63'd0, underrun}, 64'd1);
    pulse_stop();
    check("t2_stop_busy", {63'd0, busy}, 64'd0);

    // Test 4: stop with a read in flight, restart next clock
    fifo_write(16'd50);
    @(negedge clk);
    interval = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_rd_en_before_stop", {63'd0, fifo_rd_en}, 64'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t4_stopped", {63'd0, busy}, 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy", {63'd0, busy}, 64'd1);
    check("t4_underrun_clr", {63'd0, underrun}, 64'd0);
    check("t4_count_clr", {32'd0, sample_count}, 64'd0);
    for (int i = 20; i <= 23; i++) begin
      fifo_write(16'(i));
      exp_q.push_back(16'(i));
    end
    for (int i = 0; i < 4; i++) wait_strobe($sformatf("t4_s%0d", i), 30, (i > 0) ? 3 : 0);
    check("t4_count", {32'd0, sample_count}, 64'd4);
    repeat (4) @(negedge clk);
    pulse_stop();

    // Test 5: start and stop together are ignored
    fifo_write(16'd77);
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("t5_busy", {63'd0, busy}, 64'd0);
    check("t5_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    @(negedge clk);
    check("t5_rd_en_later", {63'd0, fifo_rd_en}, 64'd0);

    // Reset asserted mid-RUN
    for (int i = 78; i <= 80; i++) fifo_write(16'(i));
    exp_q.push_back(16'd77);
    pulse_start(16'd5);
    wait_strobe("t5_run", 40, 0);
    @(negedge clk);
    check("t5_mid_busy", {63'd0, busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_arst_dout", {48'd0, dout}, 64'd0);
    check("t5_arst_strobe", {63'd0, dout_strobe}, 64'd0);
    check("t5_arst_busy", {63'd0, busy}, 64'd0);
    check("t5_arst_underrun", {63'd0, underrun}, 64'd0);
    check("t5_arst_count", {32'd0, sample_count}, 64'd0);
    check("t5_arst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    @(negedge clk);
    check("t5_arst_no_strobe", {63'd0, dout_strobe}, 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
